// File: rtl/pia_bus_pkg.sv
// Shared types and encodings for the PIA bus master.
package pia_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  // PIA register select encodings
  localparam logic [1:0] RS_PA_DDRA = 2'b00;
  localparam logic [1:0] RS_CRA     = 2'b01;
  localparam logic [1:0] RS_PB_DDRB = 2'b10;
  localparam logic [1:0] RS_CRB     = 2'b11;

  // Chip-select patterns {cs2_n, cs1, cs0}
  localparam logic [2:0] CS_SELECT = 3'b011;
  localparam logic [2:0] CS_IDLE   = 3'b100;

  // Response source, one-hot
  localparam logic [1:0] RSP_SRC_CMD = 2'b00;
  localparam logic [1:0] RSP_SRC_A   = 2'b01;
  localparam logic [1:0] RSP_SRC_B   = 2'b10;

  // Counter reload value for a phase lasting n cycles (n in 1..15)
  function automatic logic [3:0] cyc_load(input int unsigned n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/pia_bus_if.sv
// PIA-side bus pins: strobe/select/data towards the PIA, data and IRQs back.
interface pia_bus_if;
  logic [2:0] pia_cs;
  logic [1:0] pia_rs;
  logic       pia_rw;
  logic       pia_enable;
  logic [7:0] pia_di;
  logic [7:0] pia_do;
  logic       pia_irqa_n;
  logic       pia_irqb_n;

  modport master (
    output pia_cs, pia_rs, pia_rw, pia_enable, pia_di,
    input  pia_do, pia_irqa_n, pia_irqb_n
  );

  modport slave (
    input  pia_cs, pia_rs, pia_rw, pia_enable, pia_di,
    output pia_do, pia_irqa_n, pia_irqb_n
  );
endinterface

// File: rtl/pia_irq_sync.sv
// Double-flop synchroniser for the two PIA IRQ lines plus a short blackout
// window after an acknowledge, so a just-released line still in the
// synchroniser cannot start a second acknowledge.
module pia_irq_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] irq_n_in,     // {irqb_n, irqa_n}, asynchronous
  input  logic       ack_done,     // acknowledge response handshake
  output logic [1:0] irq_pending,  // synchronised, active-high
  output logic       irq_block
);

  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] blk_q,  blk_d;

  // Next-state for synchroniser stages and blackout countdown
  always_comb begin
    meta_d = irq_n_in;
    sync_d = meta_q;
    blk_d  = blk_q;
    if (ack_done)
      blk_d = 2'd3;
    else if (blk_q != 2'd0)
      blk_d = blk_q - 2'd1;
  end

  // Registers; IRQ lines reset to their inactive (high) level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
      blk_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      blk_q  <= blk_d;
    end
  end

  assign irq_pending = ~sync_q;
  assign irq_block   = (blk_q != 2'd0);

endmodule

// File: rtl/pia_bus_master.sv
// Bus initiator for an MC6820-style PIA: sequences CS/RS/rw/enable cycles
// from a valid/ready command stream and returns read data as responses.
// Optional feature macro: PIA_BUS_IRQ_ACK_EN (autonomous IRQ acknowledge
// reads of port A/B).
module pia_bus_master
  import pia_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned ENABLE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [1:0] cmd_rs,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_irq,
  output logic [1:0] irq_pending,
  output logic       busy,
  pia_bus_if.master  pia
);

  state_t     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [2:0] cs_q,    cs_d;
  logic [1:0] rs_q,    rs_d;
  logic       rw_q,    rw_d;
  logic       en_q,    en_d;
  logic [7:0] di_q,    di_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] src_q,   src_d;

  logic irq_block;
  logic irq_start;
  logic ack_done;

  pia_irq_sync u_irq_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq_n_in    ({pia.pia_irqb_n, pia.pia_irqa_n}),
    .ack_done    (ack_done),
    .irq_pending (irq_pending),
    .irq_block   (irq_block)
  );

`ifdef PIA_BUS_IRQ_ACK_EN
  logic irq_sel_b;
  assign irq_start = (state_q == ST_IDLE) && !irq_block && (irq_pending != 2'b00);
  assign irq_sel_b = !irq_pending[0];  // A has priority over B
  assign ack_done  = (state_q == ST_RESP) && rsp_ready && (src_q != RSP_SRC_CMD);
`else
  // No autonomous cycles; the blackout never arms since ack_done stays low.
  assign irq_start = irq_block & 1'b0;
  assign ack_done  = 1'b0;
`endif

  assign cmd_ready = reset_n && (state_q == ST_IDLE) && !irq_start;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_irq   = src_q;
  assign busy      = (state_q != ST_IDLE);

  assign pia.pia_cs     = cs_q;
  assign pia.pia_rs     = rs_q;
  assign pia.pia_rw     = rw_q;
  assign pia.pia_enable = en_q;
  assign pia.pia_di     = di_q;

  // Next-state and registered-pin logic; counter reloads on each state
  // entry and otherwise counts down, saturating at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    cs_d    = cs_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    en_d    = en_q;
    di_d    = di_q;
    rdata_d = rdata_q;
    src_d   = src_q;

    unique case (state_q)
      ST_IDLE: begin
        if (irq_start) begin
          state_d = ST_SETUP;
          cnt_d   = cyc_load(SETUP_CYC);
          cs_d    = CS_SELECT;
          rw_d    = 1'b1;
          di_d    = '0;
`ifdef PIA_BUS_IRQ_ACK_EN
          rs_d    = irq_sel_b ? RS_PB_DDRB : RS_PA_DDRA;
          src_d   = irq_sel_b ? RSP_SRC_B : RSP_SRC_A;
`endif
        end else if (cmd_valid && cmd_ready) begin
          state_d = ST_SETUP;
          cnt_d   = cyc_load(SETUP_CYC);
          cs_d    = CS_SELECT;
          rs_d    = cmd_rs;
          rw_d    = cmd_rw;
          di_d    = cmd_wdata;
          src_d   = RSP_SRC_CMD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_STROBE;
          cnt_d   = cyc_load(ENABLE_CYC);
          en_d    = 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      end
      ST_HOLD: begin
        state_d = ST_RESP;
        cnt_d   = '0;
        cs_d    = CS_IDLE;
        rdata_d = rw_q ? pia.pia_do : 8'h00;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cs_q    <= CS_IDLE;
      rs_q    <= '0;
      rw_q    <= 1'b1;
      en_q    <= 1'b0;
      di_q    <= '0;
      rdata_q <= '0;
      src_q   <= RSP_SRC_CMD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      en_q    <= en_d;
      di_q    <= di_d;
      rdata_q <= rdata_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_pia_bus_master.sv
// Self-checking bench for pia_bus_master (randomized commands vs. a
// cycle-window reference model derived from the bus timing rules).
module tb_pia_bus_master;
  import pia_bus_pkg::*;

  localparam int unsigned S = 1;
  localparam int unsigned E = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [1:0] cmd_rs;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_irq;
  logic [1:0] irq_pending;
  logic       busy;

  pia_bus_if pia ();

  pia_bus_master #(.SETUP_CYC(S), .ENABLE_CYC(E)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_rs      (cmd_rs),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_irq     (rsp_irq),
    .irq_pending (irq_pending),
    .busy        (busy),
    .pia         (pia)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_en(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (pia.pia_enable === 1'b1) break;
      @(negedge clk);
    end
    check(tag, pia.pia_enable, 1);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) break;
      @(negedge clk);
    end
    check(tag, rsp_valid, 1);
  endtask

  // One command transaction, called and returning at a negedge in IDLE.
  // Expected enable window / response cycle come from accept cycle T:
  // enable high for T+1+S..T+S+E, response first valid at T+S+E+2.
  task automatic run_cmd(input logic rw, input logic [1:0] rs, input logic [7:0] wd,
                         input logic [7:0] pdo, input int unsigned stall);
    logic [7:0] exp_rd;
    logic       exp_en;
    exp_rd     = rw ? pdo : 8'h00;
    pia.pia_do = pdo;
    cmd_valid  = 1'b1;
    cmd_rw     = rw;
    cmd_rs     = rs;
    cmd_wdata  = wd;
    rsp_ready  = 1'b0;
    check("ready_idle", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int unsigned k = 1; k <= S + E + 2; k++) begin
      exp_en = (k >= 1 + S) && (k <= S + E);
      check("enable_window", pia.pia_enable, exp_en);
      if (k == 1 + S) begin
        check("pin_cs", pia.pia_cs, 3'b011);
        check("pin_rs", pia.pia_rs, rs);
        check("pin_rw", pia.pia_rw, rw);
        check("pin_di", pia.pia_di, wd);
      end
      if (k == S + E + 1) check("rsp_early", rsp_valid, 0);
      if (k == S + E + 2) begin
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_irq", rsp_irq, 2'b00);
        check("cs_released", pia.pia_cs, 3'b100);
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b1;  // offered while the response waits; must not be taken
    for (int unsigned i = 0; i < stall; i++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_rdata", rsp_rdata, exp_rd);
      check("stall_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("hs_ready_low", cmd_ready, 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_busy", busy, 0);
    check("post_ready", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic saw;
    reset_n        = 1'b1;
    cmd_valid      = 1'b0;
    cmd_rw         = 1'b1;
    cmd_rs         = 2'b00;
    cmd_wdata      = 8'h00;
    rsp_ready      = 1'b0;
    pia.pia_do     = 8'h00;
    pia.pia_irqa_n = 1'b1;
    pia.pia_irqb_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_irq", rsp_irq, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_cs", pia.pia_cs, 3'b100);
    check("rst_rs", pia.pia_rs, 2'b00);
    check("rst_rw", pia.pia_rw, 1);
    check("rst_en", pia.pia_enable, 0);
    check("rst_di", pia.pia_di, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Directed cases
    run_cmd(1'b0, 2'b01, 8'h04, 8'($urandom), 0);
    run_cmd(1'b1, 2'b00, 8'h00, 8'hA5, 0);
    run_cmd(1'b1, 2'b10, 8'h00, 8'h5E, 4);

    // Randomized back-to-back commands
    for (int i = 0; i < 30; i++)
      run_cmd(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 3));

    // Reset during STROBE
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_rs = 2'b11; cmd_wdata = 8'h81;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (S) @(negedge clk);
    check("mid_en_high", pia.pia_enable, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_en", pia.pia_enable, 0);
    check("mid_rst_cs", pia.pia_cs, 3'b100);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw = saw | rsp_valid | busy;
    end
    rsp_ready = 1'b0;
    check("no_rsp_after_rst", saw, 0);
    check("ready_after_mid", cmd_ready, 1);

`ifdef PIA_BUS_IRQ_ACK_EN
    // IRQ-A acknowledge
    pia.pia_do     = 8'h3C;
    pia.pia_irqa_n = 1'b0;
    @(negedge clk);
    wait_en("irqa_enable");
    check("irqa_rs", pia.pia_rs, 2'b00);
    check("irqa_rw", pia.pia_rw, 1);
    check("irqa_busy_ready", cmd_ready, 0);
    @(negedge clk);
    pia.pia_irqa_n = 1'b1;
    wait_rsp("irqa_rsp");
    check("irqa_src", rsp_irq, 2'b01);
    check("irqa_rdata", rsp_rdata, 8'h3C);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      saw = saw | busy;
      @(negedge clk);
    end
    check("irqa_no_second", saw, 0);

    // IRQ-B wins over a simultaneous command
    pia.pia_do     = 8'h5A;
    pia.pia_irqb_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (irq_pending[1] === 1'b1) break;
      @(negedge clk);
    end
    check("irqb_pending", irq_pending, 2'b10);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_rs = 2'b01; cmd_wdata = 8'h00;
    check("irqb_ready_low", cmd_ready, 0);
    wait_en("irqb_enable");
    check("irqb_rs", pia.pia_rs, 2'b10);
    pia.pia_irqb_n = 1'b1;
    wait_rsp("irqb_rsp");
    check("irqb_src", rsp_irq, 2'b10);
    check("irqb_rdata", rsp_rdata, 8'h5A);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("cmd_after_irqb", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_en("cmd2_enable");
    check("cmd2_rs", pia.pia_rs, 2'b01);
    wait_rsp("cmd2_rsp");
    check("cmd2_src", rsp_irq, 2'b00);
    check("cmd2_rdata", rsp_rdata, 8'h5A);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`else
    // IRQ lines are only synchronised/reported; no autonomous cycles
    pia.pia_irqb_n = 1'b0;
    repeat (3) @(negedge clk);
    check("pend_b", irq_pending, 2'b10);
    pia.pia_irqa_n = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw = saw | busy | rsp_valid;
    end
    check("pend_ab", irq_pending, 2'b11);
    check("no_auto_cycle", saw, 0);
    pia.pia_irqa_n = 1'b1;
    pia.pia_irqb_n = 1'b1;
    repeat (3) @(negedge clk);
    check("pend_clear", irq_pending, 2'b00);
    run_cmd(1'b1, 2'b00, 8'h00, 8'hC3, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pia_bus_master.md
# pia_bus_master

Bus initiator for the MC6820-style PIA peripheral. It sits between the system-side command stream and one PIA. It turns valid/ready register commands into correctly sequenced CS/RS/rw/enable bus cycles and returns read data as responses. With the IRQ feature compiled in, it also services PIA interrupt lines by issuing the acknowledging port reads itself.

## Interface
Parameters:
- SETUP_CYC, default 1: cycles address/data are stable before enable rises (1..15).
- ENABLE_CYC, default 2: cycles enable is held high (1..15).

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: high only in IDLE; a command transfers on cmd_valid && cmd_ready.
- cmd_rw, in, 1: 1 = read, 0 = write (PIA convention).
- cmd_rs, in, 2: PIA register select.
- cmd_wdata, in, 8: write data.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: response consumed.
- rsp_rdata, out, 8: read data; 8'h00 for writes.
- rsp_irq, out, 2: one-hot response source; 01 = IRQ-A ack, 10 = IRQ-B ack, 00 = command.
- irq_pending, out, 2: synchronised, inverted {irqB_n, irqA_n}.
- busy, out, 1: state != IDLE.
- pia_cs, out, 3: 3'b011 while a cycle is active, 3'b100 otherwise.
- pia_rs, out, 2: register select to PIA.
- pia_rw, out, 1: read/write to PIA.
- pia_enable, out, 1: PIA clock strobe; the PIA acts on its rising edge.
- pia_di, out, 8: data into PIA.
- pia_do, in, 8: data from PIA.
- pia_irqa_n, in, 1: PIA IRQ A, active-low, asynchronous.
- pia_irqb_n, in, 1: PIA IRQ B, active-low, asynchronous.

## Operation
- FSM states and transitions:
  - IDLE → SETUP on command accept or IRQ-ack start.
  - SETUP (SETUP_CYC cycles) → STROBE.
  - STROBE (ENABLE_CYC cycles, pia_enable=1) → HOLD.
  - HOLD (1 cycle, pia_enable=0, pins unchanged; pia_do captured at end of cycle) → RESP.
  - RESP (rsp_valid=1 until rsp_ready) → IDLE.
- All pia_* outputs are registered. pia_cs, pia_rs, pia_rw and pia_di are held constant from SETUP through HOLD.
- The cycle counter is 4 bits. It reloads on every state entry and saturates; there is no wrap.
- Write response: rsp_rdata = 8'h00, rsp_irq = 00.
- Only one transaction is outstanding. cmd_ready stays low from accept until the response handshake completes.
- IRQ inputs pass through 2-flop synchronisers; irq_pending reflects them at all times.
- Reset values: state IDLE, cmd_ready 0 during reset and 1 after, rsp_valid 0, rsp_rdata 8'h00, rsp_irq 00, busy 0, pia_cs 3'b100, pia_rs 00, pia_rw 1, pia_enable 0, pia_di 8'h00.
- Reset mid-cycle: all outputs return to reset values immediately. Any in-flight command is dropped without a response.

## Timing
- Accept in cycle T. The pins are driven from T+1. pia_enable is high for T+1+SETUP_CYC through T+SETUP_CYC+ENABLE_CYC.
- HOLD is the next cycle. rsp_valid is first high at T+SETUP_CYC+ENABLE_CYC+2, which is T+5 with the defaults.
- Back-to-back: the response handshake in cycle R allows a new accept in R+1 at the earliest.
- rsp_valid and rsp_rdata stay stable while rsp_ready=0.

## Configuration
- PIA_BUS_IRQ_ACK_EN defined:
  - In IDLE, a synchronised low irqA_n (priority) or irqB_n starts an internal read with pia_rs=00 (A) or 10 (B), pia_rw=1.
  - It wins over a simultaneous cmd_valid, and cmd_ready is 0 in that cycle.
  - Its response carries rsp_irq 01 or 10 and the port data.
  - After an ack response, IRQ starts are suppressed for 3 cycles so the synchroniser flushes the released line.
  - Software must leave CRx[2]=1 (port, not DDR) for the ack to clear the interrupt.
- PIA_BUS_IRQ_ACK_EN not defined: no autonomous cycles are issued, rsp_irq is tied 00, and irq_pending still operates.

## Structure
- Package pia_bus_pkg holds:
  - the state enum;
  - RS_PA_DDRA=2'b00, RS_CRA=2'b01, RS_PB_DDRB=2'b10, RS_CRB=2'b11;
  - CS_SELECT=3'b011, CS_IDLE=3'b100;
  - RSP_SRC_CMD/A/B encodings.
- Sub-module pia_irq_sync: a 2-bit double-flop synchroniser with the post-ack blackout counter.

## Test plan
- Write cmd_rs=01, cmd_wdata=8'h04:
  - pia_cs=011, pia_rw=0, pia_di=04, pia_enable high at T+2..T+3;
  - response at T+5 with rdata=00, irq=00.
- Read cmd_rs=00 with pia_do=8'hA5 → rsp_rdata=A5 at T+5.
- Hold rsp_ready=0 for 4 cycles → response stays stable, cmd_ready stays 0, and a second cmd_valid is not accepted until the cycle after the handshake.
- Assert reset_n low during STROBE → pia_enable=0 and pia_cs=100 immediately; no response after release.
- IRQ_ACK_EN build, pia_irqa_n low with pia_do=8'h3C → automatic read with rs=00 and rsp_irq=01, rdata=3C. With irqA_n released 1 cycle after enable, no second ack occurs.
- IRQ_ACK_EN build, cmd_valid and irqB_n low in the same IDLE cycle → the IRQ-B ack (rs=10) goes first, then the command is accepted.
